// File: rtl/bus_addr_decode_ctrl_if.sv
// Bus between the master, the address decoder and the slave bank.
// The decoder uses the slave modport; the master/slave environment uses the master modport.
interface bus_addr_decode_ctrl_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned NUM_SLAVES = 4
);
    logic                  m_valid;
    logic [ADDR_W-1:0]     m_addr;
    logic                  m_ready;
    logic                  m_err;
    logic [NUM_SLAVES-1:0] slave_en;
    logic [NUM_SLAVES-1:0] slave_ready;
    logic [SEL_W-1:0]      slave_output_sel;

    modport slave (
        input  m_valid,
        input  m_addr,
        input  slave_ready,
        output m_ready,
        output m_err,
        output slave_en,
        output slave_output_sel
    );

    modport master (
        output m_valid,
        output m_addr,
        output slave_ready,
        input  m_ready,
        input  m_err,
        input  slave_en,
        input  slave_output_sel
    );
endinterface

// File: rtl/bus_addr_decode_ctrl.sv
// Registered address decoder front-end: one-hot slave enable, read-mux select,
// ready return, and error completion for unmapped regions or slave timeouts.
module bus_addr_decode_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_addr_decode_ctrl_if.slave bus,
    output logic                  busy,
    output logic [7:0]            err_count
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned REG_W = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [SEL_W-1:0]      region_c;
    logic                  mapped_c;
    logic                  hit_c;
    logic                  timeout_c;
    logic                  m_ready_c;
    logic                  m_err_c;
    logic                  unused_c;
    logic [NUM_SLAVES-1:0] slave_en_q;
    logic [SEL_W-1:0]      sel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [7:0]            err_count_q;

    assign region_c  = bus.m_addr[ADDR_W-1 -: SEL_W];
    assign mapped_c  = {1'b0, region_c} < REG_W'(NUM_SLAVES);
    // slave_en_q is one-hot while ACTIVE, so this picks slave_ready[r] only
    assign hit_c     = |(bus.slave_ready & slave_en_q);
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_c  = ^bus.m_addr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ready beats a coincident timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.m_valid) begin
                    state_next = mapped_c ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                if (hit_c) begin
                    state_next = IDLE;
                end else if (timeout_c) begin
                    state_next = ERR;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Completion decode
    always_comb begin
        m_ready_c = 1'b0;
        m_err_c   = 1'b0;
        case (state)
            ACTIVE:  m_ready_c = hit_c;
            ERR: begin
                m_ready_c = 1'b1;
                m_err_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // Enable, select, timeout counter and error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            slave_en_q  <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            err_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.m_valid) begin
                        sel_q      <= region_c;
                        slave_en_q <= mapped_c ? (NUM_SLAVES'(1) << region_c) : '0;
                    end
                end
                ACTIVE: begin
                    if (hit_c || timeout_c) begin
                        slave_en_q <= '0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ERR: begin
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.m_ready          = m_ready_c;
    assign bus.m_err            = m_err_c;
    assign bus.slave_en         = slave_en_q;
    assign bus.slave_output_sel = sel_q;
    assign busy                 = (state != IDLE);
    assign err_count            = err_count_q;
endmodule

// File: tb/tb_bus_addr_decode_ctrl.sv
// Bench for bus_addr_decode_ctrl: a 4-slave and a 3-slave instance, directed
// scenarios plus random traffic, checked every cycle against a transaction model.
module tb_bus_addr_decode_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        mv  [2];
    logic [31:0] ma  [2];
    logic [3:0]  sr  [2];
    logic        busy_a, busy_b;
    logic [7:0]  errc_a, errc_b;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Transaction-level model state per instance
    bit m_busy  [2];
    int m_reg   [2];
    bit m_unmap [2];
    int m_age   [2];
    int m_errc  [2];
    int m_sel   [2];

    always #5 clk = ~clk;

    bus_addr_decode_ctrl_if #(.ADDR_W(32), .SEL_W(2), .NUM_SLAVES(4)) ifa ();
    bus_addr_decode_ctrl_if #(.ADDR_W(32), .SEL_W(2), .NUM_SLAVES(3)) ifb ();

    assign ifa.m_valid     = mv[0];
    assign ifa.m_addr      = ma[0];
    assign ifa.slave_ready = sr[0];
    assign ifb.m_valid     = mv[1];
    assign ifb.m_addr      = ma[1];
    assign ifb.slave_ready = sr[1][2:0];

    bus_addr_decode_ctrl #(.ADDR_W(32), .SEL_W(2), .NUM_SLAVES(4), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .reset(rst[0]), .bus(ifa), .busy(busy_a), .err_count(errc_a)
    );
    bus_addr_decode_ctrl #(.ADDR_W(32), .SEL_W(2), .NUM_SLAVES(3), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .reset(rst[1]), .bus(ifb), .busy(busy_b), .err_count(errc_b)
    );

    function automatic int nslaves(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model advance: a request is accepted only when idle; an accepted request
    // either errors at once (unmapped), completes on its slave's ready, or
    // errors once it has spent TIMEOUT cycles waiting.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_busy[k] = 1'b0; m_reg[k] = 0; m_unmap[k] = 1'b0;
                m_age[k] = 0; m_errc[k] = 0; m_sel[k] = 0;
            end else if (!m_busy[k]) begin
                if (mv[k]) begin
                    m_busy[k]  = 1'b1;
                    m_reg[k]   = int'(ma[k][31:30]);
                    m_unmap[k] = (m_reg[k] >= nslaves(k));
                    m_age[k]   = 0;
                    m_sel[k]   = m_reg[k];
                end
            end else if (m_unmap[k] || m_age[k] >= TIMEOUT) begin
                m_busy[k] = 1'b0;
                m_errc[k] = (m_errc[k] >= 255) ? 255 : m_errc[k] + 1;
            end else if (sr[k][m_reg[k]]) begin
                m_busy[k] = 1'b0;
            end else begin
                m_age[k]++;
            end
        end
    end

    bit         e_act, e_errcyc, e_rdy;
    logic [3:0] e_en, d_en;
    logic [1:0] d_sel;
    logic       d_rdy, d_err, d_busy;
    logic [7:0] d_errc;

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                e_act    = m_busy[k] && !m_unmap[k] && (m_age[k] < TIMEOUT);
                e_errcyc = m_busy[k] && !e_act;
                e_en     = e_act ? (4'b0001 << m_reg[k]) : 4'b0000;
                e_rdy    = e_errcyc || (e_act && sr[k][m_reg[k]]);
                if (k == 0) begin
                    d_en = ifa.slave_en; d_sel = ifa.slave_output_sel; d_rdy = ifa.m_ready;
                    d_err = ifa.m_err; d_busy = busy_a; d_errc = errc_a;
                end else begin
                    d_en = {1'b0, ifb.slave_en}; d_sel = ifb.slave_output_sel; d_rdy = ifb.m_ready;
                    d_err = ifb.m_err; d_busy = busy_b; d_errc = errc_b;
                end
                chk("slave_en",  k, 32'(d_en),   32'(e_en));
                chk("sel",       k, 32'(d_sel),  32'(m_sel[k]));
                chk("m_ready",   k, 32'(d_rdy),  32'(e_rdy));
                chk("m_err",     k, 32'(d_err),  32'(e_errcyc));
                chk("busy",      k, 32'(d_busy), 32'(m_busy[k]));
                chk("err_count", k, 32'(d_errc), 32'(m_errc[k]));
            end
        end
    end

    task automatic drive(input int k, input int n);
        bit done;
        for (int c = 0; c < n; c++) begin
            #1;
            done = (k == 0) ? ifa.m_ready : ifb.m_ready;
            tick();
            if (mv[k] && done) begin
                if ($urandom_range(0, 1) == 0) ma[k] = $urandom;
                else mv[k] = 1'b0;
            end else if (!mv[k]) begin
                ma[k] = $urandom;
                if ($urandom_range(0, 2) == 0) mv[k] = 1'b1;
            end else begin
                ma[k] = $urandom;   // decoder is busy, address must be ignored
            end
            sr[k] = 4'($urandom) & 4'($urandom) & 4'($urandom);
        end
        mv[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = '{1'b1, 1'b1};
        mv  = '{1'b0, 1'b0};
        ma  = '{32'h0, 32'h0};
        sr  = '{4'h0, 4'h0};
        repeat (3) tick();
        rst = '{1'b0, 1'b0};
        check_en = 1'b1;
        #1;
        chk("rst_en",   0, 32'(ifa.slave_en), 32'h0);
        chk("rst_sel",  0, 32'(ifa.slave_output_sel), 32'h0);
        chk("rst_busy", 0, 32'(busy_a), 32'h0);
        chk("rst_rdy",  0, 32'(ifa.m_ready), 32'h0);
        chk("rst_errc", 1, 32'(errc_b), 32'h0);

        // Region 1, ready on the third ACTIVE cycle
        mv[0] = 1'b1; ma[0] = 32'h4000_0010;
        tick();
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) sr[0] = 4'b0010;
            #1;
            chk("dflt_en",  0, 32'(ifa.slave_en), 32'h2);
            chk("dflt_sel", 0, 32'(ifa.slave_output_sel), 32'h1);
            chk("dflt_rdy", 0, 32'(ifa.m_ready), 32'(i == 3));
            tick();
        end
        mv[0] = 1'b0; sr[0] = 4'h0;
        #1;
        chk("dflt_done_en",  0, 32'(ifa.slave_en), 32'h0);
        chk("dflt_done_sel", 0, 32'(ifa.slave_output_sel), 32'h1);

        // Unmapped region 3 on the 3-slave instance
        mv[1] = 1'b1; ma[1] = 32'hC000_0000;
        tick();
        #1;
        chk("unm_en",  1, 32'(ifb.slave_en), 32'h0);
        chk("unm_rdy", 1, 32'(ifb.m_ready), 32'h1);
        chk("unm_err", 1, 32'(ifb.m_err), 32'h1);
        chk("unm_sel", 1, 32'(ifb.slave_output_sel), 32'h3);
        tick();
        mv[1] = 1'b0;
        #1;
        chk("unm_errc", 1, 32'(errc_b), 32'h1);
        chk("unm_busy", 1, 32'(busy_b), 32'h0);

        // Slave 3 selected, other slaves' ready must be ignored
        mv[0] = 1'b1; ma[0] = 32'hC000_0000;
        tick();
        sr[0] = 4'b0111;
        #1;
        chk("ign_en",  0, 32'(ifa.slave_en), 32'h8);
        chk("ign_rdy", 0, 32'(ifa.m_ready), 32'h0);
        tick();
        sr[0] = 4'b1000;
        #1;
        chk("sel3_rdy", 0, 32'(ifa.m_ready), 32'h1);
        tick();
        mv[0] = 1'b0; sr[0] = 4'h0;

        // Region 2, no ready: 16 ACTIVE cycles then one error cycle
        mv[0] = 1'b1; ma[0] = 32'h8000_0000;
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            chk("to_en",  0, 32'(ifa.slave_en), 32'h4);
            chk("to_rdy", 0, 32'(ifa.m_ready), 32'h0);
            tick();
        end
        #1;
        chk("to_done_rdy", 0, 32'(ifa.m_ready), 32'h1);
        chk("to_done_err", 0, 32'(ifa.m_err), 32'h1);
        chk("to_done_en",  0, 32'(ifa.slave_en), 32'h0);
        tick();
        mv[0] = 1'b0;
        #1;
        chk("to_busy", 0, 32'(busy_a), 32'h0);
        chk("to_errc", 0, 32'(errc_a), 32'h1);

        // Back-to-back: region 0 then region 2 with one idle cycle between
        mv[0] = 1'b1; ma[0] = 32'h0000_0000;
        tick();
        sr[0] = 4'b0001;
        #1;
        chk("b2b_en0", 0, 32'(ifa.slave_en), 32'h1);
        tick();
        sr[0] = 4'h0; ma[0] = 32'h8000_0000;
        #1;
        chk("b2b_gap_en",  0, 32'(ifa.slave_en), 32'h0);
        chk("b2b_gap_rdy", 0, 32'(ifa.m_ready), 32'h0);
        tick();
        sr[0] = 4'b0100;
        #1;
        chk("b2b_en2",  0, 32'(ifa.slave_en), 32'h4);
        chk("b2b_rdy2", 0, 32'(ifa.m_ready), 32'h1);
        tick();
        mv[0] = 1'b0; sr[0] = 4'h0;
        tick();

        // Reset while ACTIVE drops the transaction
        mv[0] = 1'b1; ma[0] = 32'h4000_0000;
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0; mv[0] = 1'b0;
        #1;
        chk("mid_rst_en",   0, 32'(ifa.slave_en), 32'h0);
        chk("mid_rst_busy", 0, 32'(busy_a), 32'h0);
        chk("mid_rst_errc", 0, 32'(errc_a), 32'h0);

        // Twenty consecutive timeouts, 18 cycles each with m_valid held
        mv[0] = 1'b1; ma[0] = 32'h4000_0000;
        repeat (20 * 18) tick();
        mv[0] = 1'b0;
        tick();
        #1;
        chk("twenty_errc", 0, 32'(errc_a), 32'd20);
        chk("twenty_busy", 0, 32'(busy_a), 32'h0);

        fork
            drive(0, 1500);
            drive(1, 1500);
        join
        sr = '{4'h0, 4'h0};
        repeat (20) tick();

        // Saturation: 300 unmapped requests on the 3-slave instance
        mv[1] = 1'b1; ma[1] = 32'hC000_0000;
        repeat (600) tick();
        mv[1] = 1'b0;
        repeat (3) tick();
        #1;
        chk("sat_errc", 1, 32'(errc_b), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
